// File: rtl/bmem_row_writer_pkg.sv
// Shared constants and FSM state encoding for the row-buffer writer and the
// matching row reader that will sit on the other port.
package bmem_row_writer_pkg;

  localparam int PIX_W     = 8;
  localparam int ROW_PIX   = 640;
  localparam int ROWS      = 480;
  localparam int ADDR_W    = $clog2(ROWS);
  localparam int ROW_W     = PIX_W * ROW_PIX;
  localparam int PIX_CNT_W = $clog2(ROW_PIX);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } bmem_state_e;

endpackage

// File: rtl/bmem_row_writer.sv
// Packs a raster pixel stream into full-row words and writes each finished
// row into the dual-port row buffer with a single-cycle write strobe.
module bmem_row_writer #(
  parameter int PIX_W   = bmem_row_writer_pkg::PIX_W,
  parameter int ROW_PIX = bmem_row_writer_pkg::ROW_PIX,
  parameter int ROWS    = bmem_row_writer_pkg::ROWS,
  parameter int ADDR_W  = $clog2(ROWS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pix_valid,
  input  logic                     pix_sof,
  input  logic [PIX_W-1:0]         pix_data,
  output logic                     pix_ready,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [PIX_W*ROW_PIX-1:0] mem_din,
  output logic                     row_done,
  output logic                     frame_done,
  output logic                     sof_err,
  output logic                     busy
);

  import bmem_row_writer_pkg::*;

  localparam int                 CNT_W    = $clog2(ROW_PIX);
  localparam int                 DIN_W    = PIX_W * ROW_PIX;
  localparam logic [CNT_W-1:0]   LAST_PIX = CNT_W'(ROW_PIX - 1);
  localparam logic [ADDR_W-1:0]  LAST_ROW = ADDR_W'(ROWS - 1);

  bmem_state_e         state_q, state_d;
  logic [CNT_W-1:0]    pix_cnt_q, pix_cnt_d;
  logic [ADDR_W-1:0]   row_cnt_q, row_cnt_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DIN_W-1:0]    mem_din_q, mem_din_d;
  logic                frame_done_q, frame_done_d;
  logic                sof_err_q, sof_err_d;
  logic                busy_q, busy_d;

  logic                accept;
  logic                pix_wr;
  logic [CNT_W-1:0]    pix_slot;

  assign pix_ready = (state_q == ST_IDLE) || (state_q == ST_FILL);
  assign accept    = pix_valid && pix_ready;

  always_comb begin
    state_d      = state_q;
    pix_cnt_d    = pix_cnt_q;
    row_cnt_d    = row_cnt_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    frame_done_d = 1'b0;
    sof_err_d    = 1'b0;
    pix_wr       = 1'b0;
    pix_slot     = pix_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept && pix_sof) begin
          pix_wr    = 1'b1;
          pix_slot  = '0;
          pix_cnt_d = CNT_W'(1);
          row_cnt_d = '0;
          state_d   = ST_FILL;
        end
      end
      ST_FILL: begin
        if (accept) begin
          pix_wr = 1'b1;
          // A fresh SOF restarts the frame even if it lands on the last column
          if (pix_sof) begin
            pix_slot  = '0;
            pix_cnt_d = CNT_W'(1);
            row_cnt_d = '0;
            sof_err_d = 1'b1;
          end else if (pix_cnt_q == LAST_PIX) begin
            pix_cnt_d  = '0;
            mem_we_d   = 1'b1;
            mem_addr_d = row_cnt_q;
            state_d    = ST_WRITE;
          end else begin
            pix_cnt_d = pix_cnt_q + CNT_W'(1);
          end
        end
      end
      ST_WRITE: begin
        if (row_cnt_q == LAST_ROW) begin
          frame_done_d = 1'b1;
          state_d      = ST_DONE;
        end else begin
          row_cnt_d = row_cnt_q + ADDR_W'(1);
          state_d   = ST_FILL;
        end
      end
      ST_DONE: begin
        row_cnt_d = '0;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // Packing register written in place: one slot decoder selects the lane
  always_comb begin
    mem_din_d = mem_din_q;
    for (int i = 0; i < ROW_PIX; i++) begin
      if (pix_wr && (pix_slot == CNT_W'(i))) begin
        mem_din_d[i*PIX_W +: PIX_W] = pix_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      pix_cnt_q    <= '0;
      row_cnt_q    <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_din_q    <= '0;
      frame_done_q <= 1'b0;
      sof_err_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pix_cnt_q    <= pix_cnt_d;
      row_cnt_q    <= row_cnt_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_din_q    <= mem_din_d;
      frame_done_q <= frame_done_d;
      sof_err_q    <= sof_err_d;
      busy_q       <= busy_d;
    end
  end

  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_din    = mem_din_q;
  assign row_done   = mem_we_q;
  assign frame_done = frame_done_q;
  assign sof_err    = sof_err_q;
  assign busy       = busy_q;

endmodule
